// File: rtl/enc16_4_rr_if.sv
// Request/issue bus of the 16-to-4 encoder: request capture on one side,
// valid/ready index handshake plus status on the other.
interface enc16_4_rr_if;
    logic        en;
    logic [15:0] r;
    logic [3:0]  y;
    logic        valid;
    logic        ready;
    logic [15:0] pending;
    logic [4:0]  count;
    logic        overflow;

    // Request source and index consumer side.
    modport master (
        output en, r, ready,
        input  y, valid, pending, count, overflow
    );

    // Encoder side.
    modport slave (
        input  en, r, ready,
        output y, valid, pending, count, overflow
    );
endinterface

// File: rtl/enc16_4_rr.sv
// Sequential 16-to-4 encoder. Request pulses are latched into a pending
// register and issued one index at a time over a valid/ready handshake,
// selected round-robin (RR=1) or lowest-index-first (RR=0).
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | output register empty, valid low
// S_HOLD | output register holds an issued index, valid high
module enc16_4_rr #(
    parameter bit RR = 1'b1,
    parameter int N  = 16,
    parameter int W  = 4
) (
    input logic         clk,
    input logic         rst_n,
    enc16_4_rr_if.slave bus
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   pending_q, pending_d;
    logic [W-1:0]   y_q, y_d;
    logic [W-1:0]   last_q, last_d;
    logic           ovf_q, ovf_d;

    logic [W-1:0]   sel;
    logic           load;
    logic [N-1:0]   load_mask;
    logic [N-1:0]   set_mask;
    logic [W:0]     count;

    // Pick the next index from registered pending only; RR scans upward
    // from the slot after the last issued index, wrapping at 15.
    always_comb begin
        logic [W-1:0] idx;
        logic         found;
        sel   = '0;
        idx   = '0;
        found = 1'b0;
        for (int k = 1; k <= N; k++) begin
            idx = RR ? W'(last_q + W'(k)) : W'(k - 1);
            if (!found && pending_q[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
        end
    end

    // Next-state, capture/clear masks and output register updates.
    always_comb begin
        state_d   = state_q;
        y_d       = y_q;
        last_d    = last_q;
        load      = 1'b0;
        load_mask = '0;
        set_mask  = bus.en ? bus.r : '0;

        if (((state_q == S_IDLE) || bus.ready) && (pending_q != '0)) begin
            load      = 1'b1;
            load_mask = N'(1) << sel;
            y_d       = sel;
            last_d    = sel;
            state_d   = S_HOLD;
        end else if ((state_q == S_HOLD) && bus.ready) begin
            state_d   = S_IDLE;
        end

        // A set landing on the bit being issued this cycle wins and is
        // not an overflow; only merges into still-pending bits are.
        pending_d = (pending_q & ~load_mask) | set_mask;
        ovf_d     = |(set_mask & pending_q & ~load_mask);
    end

    // Registers; last_q resets to 15 so the first RR scan starts at 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            pending_q <= '0;
            y_q       <= '0;
            last_q    <= W'(N - 1);
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            y_q       <= y_d;
            last_q    <= last_d;
            ovf_q     <= ovf_d;
        end
    end

    // Population count of the pending register.
    always_comb begin
        count = '0;
        for (int i = 0; i < N; i++) begin
            count = count + (W + 1)'(pending_q[i]);
        end
    end

    assign bus.y        = y_q;
    assign bus.valid    = (state_q == S_HOLD);
    assign bus.pending  = pending_q;
    assign bus.count    = count;
    assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_enc16_4_rr.sv
// Bench for enc16_4_rr: a round-robin and a fixed-priority instance receive
// identical stimulus and are compared each cycle against a behavioural model.
module tb_enc16_4_rr;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [15:0] r = '0;
    logic        ready = 1'b0;

    int total = 0;
    int bad = 0;

    enc16_4_rr_if bus_rr ();
    enc16_4_rr_if bus_fp ();

    assign bus_rr.en = en;
    assign bus_rr.r = r;
    assign bus_rr.ready = ready;
    assign bus_fp.en = en;
    assign bus_fp.r = r;
    assign bus_fp.ready = ready;

    enc16_4_rr #(.RR(1'b1)) dut_rr (.clk(clk), .rst_n(rst_n), .bus(bus_rr));
    enc16_4_rr #(.RR(1'b0)) dut_fp (.clk(clk), .rst_n(rst_n), .bus(bus_fp));

    always #5 clk = ~clk;

    // Model state, index 0 = round-robin, 1 = fixed priority.
    logic [15:0] m_pend [2];
    logic [3:0]  m_y    [2];
    bit          m_val  [2];
    int          m_last [2];
    bit          m_ovf  [2];

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            m_pend[m] = '0;
            m_y[m]    = '0;
            m_val[m]  = 1'b0;
            m_last[m] = 15;
            m_ovf[m]  = 1'b0;
        end
    endtask

    task automatic model_step(int m);
        int          s;
        logic [15:0] lm, sm;
        s  = -1;
        lm = '0;
        sm = en ? r : 16'h0;
        if ((!m_val[m] || ready) && m_pend[m] != 0) begin
            for (int k = 1; k <= 16; k++) begin
                int i;
                i = (m == 0) ? (m_last[m] + k) % 16 : k - 1;
                if (s < 0 && m_pend[m][i]) s = i;
            end
            lm = 16'(1) << s;
        end
        m_ovf[m]  = |(sm & m_pend[m] & ~lm);
        m_pend[m] = (m_pend[m] & ~lm) | sm;
        if (s >= 0) begin
            m_y[m]    = 4'(s);
            m_val[m]  = 1'b1;
            m_last[m] = s;
        end else if (m_val[m] && ready) begin
            m_val[m] = 1'b0;
        end
    endtask

    function automatic logic [26:0] obs(int m);
        if (m == 0)
            return {bus_rr.y, bus_rr.valid, bus_rr.pending, bus_rr.count, bus_rr.overflow};
        return {bus_fp.y, bus_fp.valid, bus_fp.pending, bus_fp.count, bus_fp.overflow};
    endfunction

    function automatic logic [26:0] expv(int m);
        return {m_y[m], m_val[m], m_pend[m], 5'($countones(m_pend[m])), m_ovf[m]};
    endfunction

    // One clock: the DUT and model both consume the inputs present at the edge.
    task automatic step();
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        en = 1'b0;
        r = '0;
        ready = 1'b0;
        model_reset();
        #3;
        rst_n = 1'b1;
    endtask

    task automatic drain();
        en = 1'b0;
        r = '0;
        ready = 1'b1;
        for (int n = 0; n < 20; n++) step();
    endtask

    task automatic test_reset();
        #2;
        model_reset();
        for (int m = 0; m < 2; m++) begin
            total++;
            if (obs(m) !== expv(m)) begin
                bad++;
                $display("FAIL reset dut%0d got=%h want=%h", m, obs(m), expv(m));
            end
        end
        #2;
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        en = 1'b1;
        ready = 1'b1;
        r = 16'h0001;
        for (int n = 0; n < 4; n++) begin
            step();
            r = '0;
            for (int m = 0; m < 2; m++) begin
                total++;
                if (obs(m) !== expv(m)) begin
                    bad++;
                    $display("FAIL single c%0d dut%0d got=%h want=%h", n, m, obs(m), expv(m));
                end
            end
        end
    endtask

    task automatic test_rr_wrap();
        logic [3:0] seq [$];
        int want [6] = '{0, 5, 10, 15, 0, 5};
        do_reset();
        en = 1'b1;
        ready = 1'b1;
        for (int n = 0; n < 10; n++) begin
            r = (n == 0) ? 16'h8421 : (n == 6) ? 16'h0021 : 16'h0000;
            step();
            if (bus_rr.valid) seq.push_back(bus_rr.y);
            for (int m = 0; m < 2; m++) begin
                total++;
                if (obs(m) !== expv(m)) begin
                    bad++;
                    $display("FAIL rr_wrap c%0d dut%0d got=%h want=%h", n, m, obs(m), expv(m));
                end
            end
        end
        r = '0;
        for (int i = 0; i < 6; i++) begin
            total++;
            if (i >= seq.size() || seq[i] !== 4'(want[i])) begin
                bad++;
                $display("FAIL rr_order #%0d got=%0d want=%0d", i,
                         (i < seq.size()) ? int'(seq[i]) : -1, want[i]);
            end
        end
    endtask

    task automatic test_hold();
        drain();
        en = 1'b1;
        ready = 1'b0;
        r = 16'h00F0;
        for (int n = 0; n < 11; n++) begin
            step();
            r = '0;
            if (n == 5) ready = 1'b1;
            for (int m = 0; m < 2; m++) begin
                total++;
                if (obs(m) !== expv(m)) begin
                    bad++;
                    $display("FAIL hold c%0d dut%0d got=%h want=%h", n, m, obs(m), expv(m));
                end
            end
        end
    endtask

    task automatic test_overflow();
        drain();
        en = 1'b1;
        ready = 1'b0;
        r = 16'h0009;
        for (int n = 0; n < 6; n++) begin
            step();
            r = (n == 1) ? 16'h0008 : (n == 2) ? 16'h0001 : 16'h0000;
            for (int m = 0; m < 2; m++) begin
                total++;
                if (obs(m) !== expv(m)) begin
                    bad++;
                    $display("FAIL overflow c%0d dut%0d got=%h want=%h", n, m, obs(m), expv(m));
                end
            end
        end
    endtask

    task automatic test_en_gate();
        drain();
        do_reset();
        en = 1'b0;
        ready = 1'b1;
        r = 16'hFFFF;
        for (int n = 0; n < 22; n++) begin
            step();
            en = (n == 2);
            if (n >= 3) r = '0;
            for (int m = 0; m < 2; m++) begin
                total++;
                if (obs(m) !== expv(m)) begin
                    bad++;
                    $display("FAIL en_gate c%0d dut%0d got=%h want=%h", n, m, obs(m), expv(m));
                end
            end
        end
    endtask

    task automatic test_async_reset();
        drain();
        en = 1'b1;
        ready = 1'b0;
        r = 16'h1000;
        step();
        r = 16'h0F00;
        step();
        r = '0;
        step();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        for (int m = 0; m < 2; m++) begin
            total++;
            if (obs(m) !== expv(m)) begin
                bad++;
                $display("FAIL async_reset dut%0d got=%h want=%h", m, obs(m), expv(m));
            end
        end
        #2;
        rst_n = 1'b1;
        en = 1'b1;
        ready = 1'b1;
        r = 16'h0F01;
        for (int n = 0; n < 7; n++) begin
            step();
            r = '0;
            for (int m = 0; m < 2; m++) begin
                total++;
                if (obs(m) !== expv(m)) begin
                    bad++;
                    $display("FAIL post_reset c%0d dut%0d got=%h want=%h", n, m, obs(m), expv(m));
                end
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            en = ($urandom_range(0, 3) != 0);
            r = 16'($urandom & $urandom & $urandom);
            ready = ($urandom_range(0, 2) != 0);
            step();
            for (int m = 0; m < 2; m++) begin
                total++;
                if (obs(m) !== expv(m)) begin
                    bad++;
                    $display("FAIL random c%0d dut%0d got=%h want=%h", n, m, obs(m), expv(m));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_rr_wrap();
        test_hold();
        test_overflow();
        test_en_gate();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/enc16_4_rr.md
Name: enc16_4_rr

Overview:
- Sequential 16-to-4 encoder. It is the companion of the team's 4-to-16 decoder: it converts one-hot/multi-hot request lines back into 4-bit indices.
- Incoming request pulses are latched into a pending register. The block emits one encoded index at a time on a valid/ready handshake, with round-robin or fixed-priority selection.
- Sits between request sources (buttons, decoder-driven units) and any consumer of a 4-bit index.

Parameters:
- RR, 1, selection mode: 1 = round-robin starting after the last issued index; 0 = fixed priority, lowest index first.
- N, 16, number of request lines (fixed at 16 for this block).
- W, 4, index width, log2(N).

Ports:
- Clock  in  1  rising-edge clock.
- Resetn  in  1  asynchronous active-low reset.
- En  in  1  capture enable; when 0, new requests are ignored.
- R  in  16  request lines; R[i]=1 for one or more cycles marks index i pending.
- Y  out  4  encoded index of the current output entry.
- Valid  out  1  Y holds a valid index.
- Ready  in  1  consumer accepts Y when Valid && Ready at a rising edge.
- Pending  out  16  latched, not-yet-issued requests.
- Count  out  5  population count of Pending, combinational from the Pending register, range 0..16.
- Overflow  out  1  one-cycle pulse: a request arrived on an index already pending.

Behaviour:
- Reset (Resetn=0, asynchronous):
  - Y=0, Valid=0, Pending=0, Overflow=0, Count=0.
  - Internal last-index pointer = 15, so the first round-robin search starts at index 0.
  - Reset mid-transfer discards the held entry and all pending bits.
- Capture:
  - Set mask = En ? R : 0.
  - Pending_next = (Pending & ~LoadMask) | SetMask.
  - A set on the same bit being loaded in the same cycle wins: that bit stays pending and is issued again later.
- Load condition: the output register is free, i.e. Valid=0 or (Valid && Ready), and Pending != 0. Selection uses registered Pending only; requests arriving this cycle are not eligible until the next cycle.
- Selection:
  - RR=1: first set bit scanning from (last+1) mod 16 upward, wrapping 15->0. On load, last := selected index.
  - RR=0: lowest set index.
- On load:
  - Y := index, Valid := 1, LoadMask = one-hot(index).
- Handshake:
  - Transfer occurs on a rising edge with Valid && Ready.
  - On transfer with no eligible pending bit, Valid := 0 and Y holds its last value.
  - Back-to-back: with Ready held high and requests pending, Valid stays 1 and a new Y appears every cycle.
  - While Valid && !Ready, Y and Valid are held stable and Pending keeps accumulating.
- Latency: a request captured at edge k becomes Pending at k; its earliest issue is Y/Valid at edge k+1, i.e. one cycle from request to Valid.
- Overflow:
  - Registered pulse, 1 at edge k+1 if at edge k there exists i with SetMask[i] && Pending[i] && !LoadMask[i].
  - The request is merged; no second entry is created.
  - A request on the index currently held in Y (already issued, no longer pending) is not overflow.
- En=0 gates capture only. Draining and the handshake continue.
- All 16 pending: issue order in RR mode is last+1 .. last, wrapping, one per accepted transfer.

Test Plan:
1. Reset, then R=16'h0001 for 1 cycle with En=1, Ready=1 -> next edge Pending=0001, following edge Y=0 and Valid=1, then Valid=0, Count back to 0.
2. RR=1, R=16'h8421 pulsed once, Ready=1 -> Y sequence 0,5,10,15 on consecutive cycles; a further request 16'h0021 -> Y=0 then 5, because the pointer is at 15 and wraps to 0.
3. RR=0, Pending=16'h00F0, Ready=0 for 5 cycles -> Y=4, Valid stable; then Ready=1 -> Y=5,6,7, then Valid=0.
4. Ready=0 with index 3 pending; pulse R[3] again -> Overflow=1 for exactly one cycle, Count unchanged at 1.
5. En=0 with R=16'hFFFF -> Pending unchanged and no Valid; toggle En=1 for 1 cycle -> Count=16, then 16 indices drained in RR order 0..15.
6. Assert Resetn=0 mid-drain while Valid=1 and Pending=16'h0F00 -> Valid, Y, Pending and Count all 0 immediately, without waiting for a clock edge; after release the first issue starts at index 0.
